// File: rtl/bip_control_unit_if.sv
// Program-memory fetch port of the BIP control unit: valid-handshaked request/instruction pair.
interface bip_control_unit_if #(
    parameter int PC_W    = 11,
    parameter int INSTR_W = 16
);
    logic               instr_req;
    logic [PC_W-1:0]    instr_addr;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;

    modport master (
        output instr_req,
        output instr_addr,
        input  instr,
        input  instr_valid
    );

    modport slave (
        input  instr_req,
        input  instr_addr,
        output instr,
        output instr_valid
    );
endinterface

// File: rtl/bip_control_unit.sv
// BIP multi-cycle control unit: fetch over a valid handshake, one-cycle EXEC strobes, HLT parking.
// Optional macro BIP_BRANCH_EN adds JMP/BEQ/BNE; undefined, those opcodes decode as illegal NOPs.
module bip_control_unit #(
    parameter int PC_W      = 11,
    parameter int OPCODE_W  = 5,
    parameter int OPERAND_W = 11
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_start,
    input  logic                 i_acc_zero,
    bip_control_unit_if.master   bus_if,
    output logic [OPERAND_W-1:0] o_operand,
    output logic [1:0]           o_sel_a,
    output logic                 o_sel_b,
    output logic                 o_write_acc,
    output logic                 o_operacion,
    output logic                 o_write_ram,
    output logic                 o_read_ram,
    output logic                 o_busy,
    output logic                 o_halted,
    output logic                 o_illegal
);
    localparam int INSTR_W = OPCODE_W + OPERAND_W;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StExec  = 2'd2,
        StHalt  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [PC_W-1:0]      r_pc;
    logic [PC_W-1:0]      w_pc_next;
    logic [INSTR_W-1:0]   r_ir;
    logic                 w_ir_load;
    logic [OPCODE_W-1:0]  w_opcode;
    logic [OPERAND_W-1:0] w_operand;
    logic                 w_opcode_hi_ok;

    assign w_opcode       = r_ir[INSTR_W-1:OPERAND_W];
    assign w_operand      = r_ir[OPERAND_W-1:0];
    // Opcode bits above [4:0] must be zero for any defined instruction.
    assign w_opcode_hi_ok = ((w_opcode >> 5) == '0);

`ifdef BIP_BRANCH_EN
    logic [PC_W-1:0] w_target;
    if (OPERAND_W >= PC_W) begin : g_target_trunc
        assign w_target = w_operand[PC_W-1:0];
    end else begin : g_target_ext
        assign w_target = {{(PC_W - OPERAND_W){1'b0}}, w_operand};
    end
`else
    logic w_unused_acc_zero;
    assign w_unused_acc_zero = i_acc_zero;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_ir_load) begin
                r_ir <= bus_if.instr;
            end
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_ir_load        = 1'b0;
        bus_if.instr_req = 1'b0;
        o_sel_a          = 2'b00;
        o_sel_b          = 1'b0;
        o_write_acc      = 1'b0;
        o_operacion      = 1'b0;
        o_write_ram      = 1'b0;
        o_read_ram       = 1'b0;
        o_busy           = 1'b0;
        o_halted         = 1'b0;
        o_illegal        = 1'b0;

        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next = StFetch;
                end
            end
            StFetch: begin
                o_busy           = 1'b1;
                bus_if.instr_req = 1'b1;
                if (bus_if.instr_valid) begin
                    w_ir_load    = 1'b1;
                    w_state_next = StExec;
                end
            end
            StExec: begin
                o_busy       = 1'b1;
                w_state_next = StFetch;
                w_pc_next    = r_pc + PC_W'(1);
                if (!w_opcode_hi_ok) begin
                    o_illegal = 1'b1;
                end else begin
                    case (w_opcode[4:0])
                        5'h00: begin
                            w_state_next = StHalt;
                            w_pc_next    = r_pc;
                        end
                        5'h01: o_write_ram = 1'b1;
                        5'h02: begin
                            o_write_acc = 1'b1;
                            o_read_ram  = 1'b1;
                        end
                        5'h03: begin
                            o_write_acc = 1'b1;
                            o_sel_a     = 2'b01;
                        end
                        5'h04, 5'h06: begin
                            o_write_acc = 1'b1;
                            o_read_ram  = 1'b1;
                            o_sel_a     = 2'b10;
                            o_operacion = w_opcode[1];
                        end
                        5'h05, 5'h07: begin
                            o_write_acc = 1'b1;
                            o_sel_a     = 2'b10;
                            o_sel_b     = 1'b1;
                            o_operacion = w_opcode[1];
                        end
`ifdef BIP_BRANCH_EN
                        5'h08: w_pc_next = w_target;
                        5'h09: if (i_acc_zero) w_pc_next = w_target;
                        5'h0A: if (!i_acc_zero) w_pc_next = w_target;
`endif
                        default: o_illegal = 1'b1;
                    endcase
                end
            end
            StHalt: begin
                o_halted = 1'b1;
                if (i_start) begin
                    w_state_next = StFetch;
                    w_pc_next    = '0;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign bus_if.instr_addr = r_pc;
    assign o_operand         = w_operand;

endmodule

// File: tb/tb_bip_control_unit.sv
// Self-checking bench for bip_control_unit: table-driven instruction stream plus directed corners.
module tb_bip_control_unit;
    localparam int PC_W    = 11;
    localparam int OPC_W   = 5;
    localparam int OPR_W   = 11;
    localparam int INSTR_W = OPC_W + OPR_W;
`ifdef BIP_BRANCH_EN
    localparam bit BR = 1'b1;
`else
    localparam bit BR = 1'b0;
`endif

    typedef struct {
        logic [15:0] instr;
        logic        z;
        logic [7:0]  fl;
        logic [10:0] addr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start4 = 1'b0;
    logic acc_zero = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bip_control_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();
    bip_control_unit_if #(.PC_W(4), .INSTR_W(INSTR_W)) bus4 ();

    logic [OPR_W-1:0] o_operand, o_operand4;
    logic [1:0]       o_sel_a, o_sel_a4;
    logic o_sel_b, o_write_acc, o_operacion, o_write_ram, o_read_ram;
    logic o_busy, o_halted, o_illegal;
    logic o_sel_b4, o_write_acc4, o_operacion4, o_write_ram4, o_read_ram4;
    logic o_busy4, o_halted4, o_illegal4;

    bip_control_unit #(.PC_W(PC_W), .OPCODE_W(OPC_W), .OPERAND_W(OPR_W)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_start    (start),
        .i_acc_zero (acc_zero),
        .bus_if     (bus),
        .o_operand  (o_operand),
        .o_sel_a    (o_sel_a),
        .o_sel_b    (o_sel_b),
        .o_write_acc(o_write_acc),
        .o_operacion(o_operacion),
        .o_write_ram(o_write_ram),
        .o_read_ram (o_read_ram),
        .o_busy     (o_busy),
        .o_halted   (o_halted),
        .o_illegal  (o_illegal)
    );

    bip_control_unit #(.PC_W(4), .OPCODE_W(OPC_W), .OPERAND_W(OPR_W)) dut4 (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_start    (start4),
        .i_acc_zero (1'b0),
        .bus_if     (bus4),
        .o_operand  (o_operand4),
        .o_sel_a    (o_sel_a4),
        .o_sel_b    (o_sel_b4),
        .o_write_acc(o_write_acc4),
        .o_operacion(o_operacion4),
        .o_write_ram(o_write_ram4),
        .o_read_ram (o_read_ram4),
        .o_busy     (o_busy4),
        .o_halted   (o_halted4),
        .o_illegal  (o_illegal4)
    );

    function automatic logic [15:0] mk(input logic [4:0] opc, input logic [10:0] opr);
        return {opc, opr};
    endfunction

    // {wa, sel_a, sel_b, op, wr, rd, illegal}
    function automatic logic [7:0] flags();
        return {o_write_acc, o_sel_a, o_sel_b, o_operacion, o_write_ram, o_read_ram, o_illegal};
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge inside EXEC after checking its strobes.
    task automatic run_instr(input logic [15:0] ins, input logic z, input logic [7:0] fl,
                             input logic [10:0] addr, input int idx);
        int n = 0;
        while (bus.instr_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req", idx, 32'(bus.instr_req), 32'd1);
        check("fetch_addr", idx, 32'(bus.instr_addr), 32'(addr));
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        acc_zero        = z;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        check("strobes", idx, 32'(flags()), 32'(fl));
        check("operand", idx, 32'(o_operand), 32'(ins[10:0]));
        check("busy_exec", idx, 32'(o_busy), 32'd1);
    endtask

    vec_t v[12];

    initial begin
        v[0]  = '{instr: mk(5'h03, 11'h005), z: 1'b0, fl: 8'hA0, addr: 11'd0};
        v[1]  = '{instr: mk(5'h05, 11'h003), z: 1'b0, fl: 8'hD0, addr: 11'd1};
        v[2]  = '{instr: mk(5'h01, 11'h010), z: 1'b0, fl: 8'h04, addr: 11'd2};
        v[3]  = '{instr: mk(5'h02, 11'h007), z: 1'b0, fl: 8'h82, addr: 11'd3};
        v[4]  = '{instr: mk(5'h04, 11'h002), z: 1'b0, fl: 8'hC2, addr: 11'd4};
        v[5]  = '{instr: mk(5'h06, 11'h001), z: 1'b0, fl: 8'hCA, addr: 11'd5};
        v[6]  = '{instr: mk(5'h07, 11'h009), z: 1'b0, fl: 8'hD8, addr: 11'd6};
        v[7]  = '{instr: mk(5'h1F, 11'h123), z: 1'b0, fl: 8'h01, addr: 11'd7};
        v[8]  = '{instr: mk(5'h09, 11'h020), z: 1'b1, fl: BR ? 8'h00 : 8'h01, addr: 11'd8};
        v[9]  = '{instr: mk(5'h09, 11'h030), z: 1'b0, fl: BR ? 8'h00 : 8'h01,
                  addr: BR ? 11'h020 : 11'd9};
        v[10] = '{instr: mk(5'h0A, 11'h040), z: 1'b0, fl: BR ? 8'h00 : 8'h01,
                  addr: BR ? 11'h021 : 11'd10};
        v[11] = '{instr: mk(5'h00, 11'h000), z: 1'b0, fl: 8'h00,
                  addr: BR ? 11'h040 : 11'd11};

        bus.instr        = '0;
        bus.instr_valid  = 1'b0;
        bus4.instr       = '0;
        bus4.instr_valid = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_strobes", 0, 32'(flags()), 32'd0);
        check("rst_busy", 0, 32'(o_busy), 32'd0);
        check("rst_halted", 0, 32'(o_halted), 32'd0);
        check("rst_req", 0, 32'(bus.instr_req), 32'd0);
        check("rst_addr", 0, 32'(bus.instr_addr), 32'd0);
        check("rst_operand", 0, 32'(o_operand), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        check("idle_req", 0, 32'(bus.instr_req), 32'd0);
        check("idle_operand", 0, 32'(o_operand), 32'd0);

        // Full opcode table, 0-wait memory
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            run_instr(v[i].instr, v[i].z, v[i].fl, v[i].addr, i);
        end
        @(negedge clk);
        check("tbl_halted", 0, 32'(o_halted), 32'd1);
        check("tbl_halt_req", 0, 32'(bus.instr_req), 32'd0);
        check("tbl_halt_addr", 0, 32'(bus.instr_addr), BR ? 32'h40 : 32'd11);

        // Restart from HALT with wait states; i_start in FETCH must be ignored
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            start = 1'b1;
            check("wait_req", k, 32'(bus.instr_req), 32'd1);
            check("wait_addr", k, 32'(bus.instr_addr), 32'd0);
            check("wait_strobes", k, 32'(flags()), 32'd0);
            check("wait_busy", k, 32'(o_busy), 32'd1);
            @(negedge clk);
        end
        start = 1'b0;
        run_instr(mk(5'h03, 11'h005), 1'b0, 8'hA0, 11'd0, 100);
        run_instr(mk(5'h05, 11'h003), 1'b0, 8'hD0, 11'd1, 101);
        run_instr(mk(5'h01, 11'h010), 1'b0, 8'h04, 11'd2, 102);
        run_instr(mk(5'h00, 11'h000), 1'b0, 8'h00, 11'd3, 103);
        bus.instr       = mk(5'h03, 11'h001);
        bus.instr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("halt_halted", k, 32'(o_halted), 32'd1);
            check("halt_req", k, 32'(bus.instr_req), 32'd0);
            check("halt_pc", k, 32'(bus.instr_addr), 32'd3);
            check("halt_strobes", k, 32'(flags()), 32'd0);
            check("halt_busy", k, 32'(o_busy), 32'd0);
        end
        bus.instr_valid = 1'b0;

        // Reset asserted during EXEC of SUB
        pulse_start();
        run_instr(mk(5'h03, 11'h004), 1'b0, 8'hA0, 11'd0, 200);
        run_instr(mk(5'h06, 11'h011), 1'b0, 8'hCA, 11'd1, 201);
        rst_n = 1'b0;
        #1;
        check("rstx_strobes", 0, 32'(flags()), 32'd0);
        check("rstx_busy", 0, 32'(o_busy), 32'd0);
        check("rstx_addr", 0, 32'(bus.instr_addr), 32'd0);
        check("rstx_operand", 0, 32'(o_operand), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstx_idle_req", 0, 32'(bus.instr_req), 32'd0);
        pulse_start();
        check("rstx_refetch_req", 0, 32'(bus.instr_req), 32'd1);
        check("rstx_refetch_addr", 0, 32'(bus.instr_addr), 32'd0);

        // PC_W=4 wrap: 17 fetches, the 17th from address 0
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < 17; i++) begin
            int n = 0;
            while (bus4.instr_req !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("w4_req", i, 32'(bus4.instr_req), 32'd1);
            check("w4_addr", i, 32'(bus4.instr_addr), 32'(i % 16));
            bus4.instr       = mk(5'h03, 11'(i));
            bus4.instr_valid = 1'b1;
            @(negedge clk);
            bus4.instr_valid = 1'b0;
            check("w4_wa", i, 32'(o_write_acc4), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
